ifu_fetch: RTL and testbench

- Instruction fetch initiator paired with the instruction memory.
- Generates sequential word addresses from a PC register and issues them on a valid/ready request channel.
- Accepts in-order instruction responses and buffers them in a small FIFO for the decoder.
- Handles branch/jump redirects by flushing the buffer and discarding stale in-flight responses.

---
 rtl/ifu_pkg.sv | 30 +++
 rtl/ifu_fifo.sv | 70 +++++++
 rtl/ifu_fetch.sv | 168 ++++++++++++++++
 tb/tb_ifu_fetch.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ifu_pkg.sv
// ---------------------------------------------------------------------------
// ifu_pkg
// Shared definitions for the instruction fetch unit:
//   - fetch_state_e : fetch FSM encoding (ST_HALT only reachable when the
//                     IFU_MISALIGN_TRAP_EN build option is enabled)
//   - INST_STEP     : byte distance between sequential instructions
//   - buf_entry_t   : one instruction-buffer entry {pc, inst}
// ---------------------------------------------------------------------------
package ifu_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_DRAIN = 2'd2,
      ST_HALT  = 2'd3
   } fetch_state_e;

   localparam int unsigned INST_STEP = 4;

   // Field widths match the default ADDR_W / INST_W of ifu_fetch; the top
   // converts to and from its own parameter widths with sized casts.
   localparam int unsigned ENTRY_ADDR_W = 32;
   localparam int unsigned ENTRY_INST_W = 32;

   typedef struct packed {
      logic [ENTRY_ADDR_W-1:0] pc;
      logic [ENTRY_INST_W-1:0] inst;
   } buf_entry_t;

endpackage

// File: rtl/ifu_fifo.sv
// ---------------------------------------------------------------------------
// ifu_fifo
// Small synchronous FIFO with a combinational head read.
// DEPTH must be a power of two (pointers wrap naturally).
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   push, wdata     write request / data (ignored when full or flushing)
//   pop             remove the head entry (ignored when empty or flushing)
//   flush           empty the FIFO; wins over push and pop
//   rdata           head entry (undefined content while empty)
//   count           number of stored entries, 0..DEPTH
//   empty, full     status flags
// ---------------------------------------------------------------------------
module ifu_fifo #(
   parameter int unsigned DEPTH = 2,
   parameter int unsigned W     = 8
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       push,
   input  logic                       pop,
   input  logic                       flush,
   input  logic [W-1:0]               wdata,
   output logic [W-1:0]               rdata,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       empty,
   output logic                       full
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   cnt;
   logic          do_push;
   logic          do_pop;

   assign empty   = (cnt == '0);
   assign full    = (cnt == (AW+1)'(DEPTH));
   assign do_push = push & ~full & ~flush;
   assign do_pop  = pop & ~empty & ~flush;
   assign rdata   = mem[rd_ptr];
   assign count   = cnt;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         cnt <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
      end
   end

   // NOTE: the storage array has no reset; entries are only visible once
   // counted, so clearing them would cost reset fan-out for nothing.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end

endmodule

// File: rtl/ifu_fetch.sv
// ---------------------------------------------------------------------------
// ifu_fetch
// Instruction fetch initiator. Issues sequential word addresses from the PC
// on a valid/ready request channel, buffers in-order responses for the
// decoder and handles redirects by flushing the buffer and dropping stale
// in-flight responses. Requests are credit-limited so that every response
// always finds room in the buffer.
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   imem_req_valid/ready, imem_addr  fetch request channel (word aligned)
//   imem_rsp_valid, imem_rsp_inst    in-order fetch responses
//   inst_valid/ready, inst, inst_pc  buffered instruction to the decoder
//   redirect_valid, redirect_pc      branch/jump redirect (highest priority)
//   fetch_fault                      sticky misaligned-redirect flag
//                                    (only with IFU_MISALIGN_TRAP_EN)
// Build option: define IFU_MISALIGN_TRAP_EN to trap misaligned redirect
// targets into a HALT state instead of silently clearing bits [1:0].
// ---------------------------------------------------------------------------
module ifu_fetch
   import ifu_pkg::*;
#(
   parameter int unsigned       ADDR_W    = 32,
   parameter int unsigned       INST_W    = 32,
   parameter logic [ADDR_W-1:0] PC_RST    = 32'h8000_0000,
   parameter int unsigned       BUF_DEPTH = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   output logic              imem_req_valid,
   input  logic              imem_req_ready,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic              imem_rsp_valid,
   input  logic [INST_W-1:0] imem_rsp_inst,
   output logic              inst_valid,
   input  logic              inst_ready,
   output logic [INST_W-1:0] inst,
   output logic [ADDR_W-1:0] inst_pc,
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_pc
`ifdef IFU_MISALIGN_TRAP_EN
  ,output logic              fetch_fault
`endif
);

   localparam int unsigned CW      = $clog2(BUF_DEPTH) + 1;
   localparam logic [CW:0] DEPTH_C = (CW+1)'(BUF_DEPTH);

   fetch_state_e      state_q, state_d;
   logic [ADDR_W-1:0] pc_q;
   logic [CW-1:0]     drop_q, drop_d;
   logic [CW-1:0]     buf_cnt, pcq_cnt;
   logic              buf_empty, buf_full, pcq_empty, pcq_full;
   logic [ADDR_W-1:0] rsp_pc;
   buf_entry_t        buf_wdata, buf_rdata;
   logic              credit_ok;
   logic              req_fire, rsp_take, rsp_drop, rsp_keep, pop_fire;

   // The in-flight PC queue tracks exactly the outstanding requests, so its
   // occupancy doubles as the outstanding counter.
   assign req_fire  = imem_req_valid & imem_req_ready;
   assign rsp_take  = imem_rsp_valid & ~pcq_empty;
   assign rsp_drop  = rsp_take & (drop_q != '0);
   assign rsp_keep  = rsp_take & (drop_q == '0) & ~redirect_valid & ~buf_full;
   assign pop_fire  = inst_valid & inst_ready & ~redirect_valid;
   assign credit_ok = (({1'b0, buf_cnt} + {1'b0, pcq_cnt}) < DEPTH_C) & ~pcq_full;

   ifu_fifo #(.DEPTH(BUF_DEPTH), .W(ADDR_W)) u_pcq (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (req_fire),
      .pop   (rsp_take),
      .flush (1'b0),
      .wdata (pc_q),
      .rdata (rsp_pc),
      .count (pcq_cnt),
      .empty (pcq_empty),
      .full  (pcq_full)
   );

   always_comb begin
      buf_wdata      = '0;
      buf_wdata.pc   = ENTRY_ADDR_W'(rsp_pc);
      buf_wdata.inst = ENTRY_INST_W'(imem_rsp_inst);
   end

   ifu_fifo #(.DEPTH(BUF_DEPTH), .W($bits(buf_entry_t))) u_buf (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (rsp_keep),
      .pop   (pop_fire),
      .flush (redirect_valid),
      .wdata (buf_wdata),
      .rdata (buf_rdata),
      .count (buf_cnt),
      .empty (buf_empty),
      .full  (buf_full)
   );

   assign inst_valid = ~buf_empty;
   assign inst       = inst_valid ? INST_W'(buf_rdata.inst) : '0;
   assign inst_pc    = inst_valid ? ADDR_W'(buf_rdata.pc) : '0;
   assign imem_addr  = pc_q;

   // Everything in flight at a redirect is stale, including a request
   // accepted in that same cycle, minus a response that retires in it.
   always_comb begin
      drop_d = drop_q;
      if (redirect_valid) begin
         drop_d = pcq_cnt + CW'(req_fire) - CW'(rsp_take);
      end else if (rsp_drop) begin
         drop_d = drop_q - CW'(1);
      end
   end

   // NOTE: every output of this block gets a default first, so no path
   // leaves a signal unassigned and no latch is inferred.
   always_comb begin
      state_d        = state_q;
      imem_req_valid = 1'b0;
      case (state_q)
         ST_IDLE:  state_d = ST_FETCH;
         ST_FETCH: imem_req_valid = credit_ok;
         ST_DRAIN: if (drop_q == '0) state_d = ST_FETCH;
`ifdef IFU_MISALIGN_TRAP_EN
         ST_HALT:  state_d = ST_HALT;
`endif
         default:  state_d = ST_IDLE;
      endcase
      if (redirect_valid) begin
         state_d = (drop_d != '0) ? ST_DRAIN : ST_FETCH;
`ifdef IFU_MISALIGN_TRAP_EN
         if ((redirect_pc[1:0] != 2'b00) || (state_q == ST_HALT)) state_d = ST_HALT;
`endif
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         pc_q    <= PC_RST;
         drop_q  <= '0;
      end else begin
         state_q <= state_d;
         drop_q  <= drop_d;
         if (redirect_valid) begin
            pc_q <= redirect_pc & ~ADDR_W'(3);
         end else if (req_fire) begin
            pc_q <= pc_q + ADDR_W'(INST_STEP);
         end
      end
   end

`ifdef IFU_MISALIGN_TRAP_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_fault <= 1'b0;
      end else if (redirect_valid && (redirect_pc[1:0] != 2'b00)) begin
         fetch_fault <= 1'b1;
      end
   end
`endif

   // A response with nothing outstanding is a memory protocol error; it is
   // ignored by the datapath above.
   rsp_protocol_a: assert property (@(posedge clk) disable iff (!rst_n)
      imem_rsp_valid |-> !pcq_empty);

endmodule

// File: tb/tb_ifu_fetch.sv
// ---------------------------------------------------------------------------
// tb_ifu_fetch
// Self-checking bench for ifu_fetch. A memory model answers accepted
// requests in order after a programmable latency; a reference address
// sequence checks every accepted request, and a scoreboard queue of
// expected {pc, inst} pairs is filled as fresh responses are driven and
// drained as the decoder side consumes instructions.
// ---------------------------------------------------------------------------
module tb_ifu_fetch;

   localparam logic [31:0] PC_RST = 32'h8000_0000;

   logic        clk;
   logic        rst_n;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_inst;
   logic        inst_valid;
   logic        inst_ready;
   logic [31:0] inst;
   logic [31:0] inst_pc;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
`ifdef IFU_MISALIGN_TRAP_EN
   logic        fetch_fault;
`endif

   ifu_fetch dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_addr      (imem_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_inst  (imem_rsp_inst),
      .inst_valid     (inst_valid),
      .inst_ready     (inst_ready),
      .inst           (inst),
      .inst_pc        (inst_pc),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc)
`ifdef IFU_MISALIGN_TRAP_EN
     ,.fetch_fault    (fetch_fault)
`endif
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      logic [31:0] addr;
      int          due;
      int          tag;
   } req_t;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] inst;
   } exp_t;

   req_t        rsp_q[$];
   exp_t        exp_q[$];
   int          n_checks = 0;
   int          n_errors = 0;
   int          cyc = 0;
   int          epoch = 0;
   int          n_acc = 0;
   int          n_pop = 0;
   logic [31:0] exp_addr = PC_RST;
   logic [31:0] first_pc = '0;
   logic        want_first = 1'b0;
   logic        chk_after_redir = 1'b0;

   // Controls written by the main sequence, sampled by the model.
   logic        ctl_req_ready = 1'b1;
   logic        ctl_inst_ready = 1'b1;
   int          ctl_lat = 1;
   logic        redir_arm = 1'b0;
   int          redir_mode = 0;
   logic [31:0] redir_target = '0;
   logic        redir_done = 1'b0;

   function automatic logic [31:0] mem_fn(input logic [31:0] a);
      return {a[15:0], ~a[15:0]} ^ 32'h0F0F_3C3C;
   endfunction

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(negedge clk);
         #1;
      end
   endtask

   // Memory model, redirect generator and scoreboard; runs at every negedge
   // and drives the inputs seen by the following rising edge.
   task automatic run_model();
      req_t r;
      req_t nr;
      exp_t e;
      logic acc;
      logic redir;
      logic rsp_now;
      forever begin
         @(negedge clk);
         cyc++;
         if (!rst_n) begin
            rsp_q.delete();
            exp_q.delete();
            epoch           = 0;
            exp_addr        = PC_RST;
            n_acc           = 0;
            n_pop           = 0;
            want_first      = 1'b0;
            chk_after_redir = 1'b0;
            imem_rsp_valid  = 1'b0;
            redirect_valid  = 1'b0;
            continue;
         end
         if (chk_after_redir) begin
            check("inst_valid_after_redirect", 64'(inst_valid), 64'(0));
            chk_after_redir = 1'b0;
         end
         imem_req_ready = ctl_req_ready;
         inst_ready     = ctl_inst_ready;

         rsp_now = 1'b0;
         r       = '{addr: '0, due: 0, tag: 0};
         if (rsp_q.size() > 0 && rsp_q[0].due <= cyc) begin
            r       = rsp_q.pop_front();
            rsp_now = 1'b1;
         end
         imem_rsp_valid = rsp_now;
         imem_rsp_inst  = rsp_now ? mem_fn(r.addr) : 32'hDEAD_BEEF;

         acc   = imem_req_valid & imem_req_ready;
         redir = 1'b0;
         if (redir_arm) begin
            case (redir_mode)
               0:       redir = 1'b1;
               1:       redir = !rsp_now && (rsp_q.size() == 2);
               default: redir = acc && rsp_now;
            endcase
         end
         redirect_valid = redir;
         redirect_pc    = redir ? redir_target : $urandom;

         if (inst_valid && inst_ready && !redir) begin
            if (exp_q.size() == 0) begin
               check("unexpected_inst", 64'(exp_q.size()), 64'(1));
            end else begin
               e = exp_q.pop_front();
               check("inst_pc", 64'(inst_pc), 64'(e.pc));
               check("inst", 64'(inst), 64'(e.inst));
               n_pop++;
               if (want_first) begin
                  first_pc   = inst_pc;
                  want_first = 1'b0;
               end
            end
         end
         if (rsp_now && (r.tag == epoch) && !redir) begin
            e.pc   = r.addr;
            e.inst = mem_fn(r.addr);
            exp_q.push_back(e);
         end
         if (acc) begin
            check("req_addr", 64'(imem_addr), 64'(exp_addr));
            nr.addr = imem_addr;
            nr.due  = cyc + ctl_lat;
            nr.tag  = epoch;
            rsp_q.push_back(nr);
            exp_addr = exp_addr + 32'd4;
            n_acc++;
         end
         if (redir) begin
            epoch++;
            exp_q.delete();
            exp_addr        = redir_target & ~32'h3;
            redir_arm       = 1'b0;
            redir_done      = 1'b1;
            want_first      = 1'b1;
            first_pc        = '0;
            chk_after_redir = 1'b1;
         end
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      check("rst_req_valid", 64'(imem_req_valid), 64'(0));
      check("rst_addr", 64'(imem_addr), 64'(PC_RST));
      check("rst_inst_valid", 64'(inst_valid), 64'(0));
      tick(3);
      rst_n = 1'b1;
   endtask

   task automatic wait_redir();
      for (int i = 0; i < 100 && !redir_done; i++) tick(1);
      check("redirect_fired", 64'(redir_done), 64'(1));
   endtask

   initial begin
      rst_n          = 1'b0;
      imem_req_ready = 1'b0;
      imem_rsp_valid = 1'b0;
      imem_rsp_inst  = '0;
      inst_ready     = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      fork
         run_model();
      join_none

      // Reset values
      tick(1);
      check("reset_req_valid", 64'(imem_req_valid), 64'(0));
      check("reset_addr", 64'(imem_addr), 64'(PC_RST));
      check("reset_inst_valid", 64'(inst_valid), 64'(0));
      check("reset_inst", 64'(inst), 64'(0));
      check("reset_inst_pc", 64'(inst_pc), 64'(0));
`ifdef IFU_MISALIGN_TRAP_EN
      check("reset_fetch_fault", 64'(fetch_fault), 64'(0));
`endif
      tick(3);
      rst_n = 1'b1;

      // Sequential streaming, 1-cycle memory, decoder always ready
      tick(30);
      check("stream_progress", 64'(n_pop >= 8), 64'(1));

      // Decoder stalled: credits stop at two requests, head holds still
      ctl_inst_ready = 1'b0;
      do_reset();
      tick(10);
      check("stall_accepts", 64'(n_acc), 64'(2));
      check("stall_req_valid", 64'(imem_req_valid), 64'(0));
      check("stall_inst_valid", 64'(inst_valid), 64'(1));
      check("stall_inst_pc", 64'(inst_pc), 64'(PC_RST));
      tick(4);
      check("stall_inst_pc_hold", 64'(inst_pc), 64'(PC_RST));
      ctl_inst_ready = 1'b1;
      tick(15);
      check("stall_release_progress", 64'(n_pop >= 4), 64'(1));

      // Memory not ready: address holds, no PC advance
      ctl_req_ready = 1'b0;
      do_reset();
      tick(2);
      for (int i = 0; i < 3; i++) begin
         check("backpressure_valid", 64'(imem_req_valid), 64'(1));
         check("backpressure_addr", 64'(imem_addr), 64'(PC_RST));
         tick(1);
      end
      ctl_req_ready = 1'b1;
      tick(12);
      check("backpressure_release", 64'(n_acc >= 3), 64'(1));

      // Redirect with two responses in flight
      ctl_lat = 3;
      do_reset();
      redir_done   = 1'b0;
      redir_target = 32'h8000_0100;
      redir_mode   = 1;
      redir_arm    = 1'b1;
      wait_redir();
      tick(30);
      check("redirect_inflight_first_pc", 64'(first_pc), 64'(32'h8000_0100));

      // Redirect coinciding with a response and a request acceptance
      ctl_lat = 1;
      do_reset();
      redir_done   = 1'b0;
      redir_target = 32'h8000_0200;
      redir_mode   = 2;
      redir_arm    = 1'b1;
      wait_redir();
      tick(25);
      check("redirect_coincident_first_pc", 64'(first_pc), 64'(32'h8000_0200));

`ifdef IFU_MISALIGN_TRAP_EN
      // Misaligned redirect traps into HALT until reset
      begin
         int acc0;
         ctl_lat = 2;
         do_reset();
         tick(6);
         redir_done   = 1'b0;
         redir_target = 32'h8000_0102;
         redir_mode   = 0;
         redir_arm    = 1'b1;
         wait_redir();
         tick(1);
         acc0 = n_acc;
         check("halt_fault", 64'(fetch_fault), 64'(1));
         tick(15);
         check("halt_no_requests", 64'(n_acc), 64'(acc0));
         check("halt_req_valid", 64'(imem_req_valid), 64'(0));
         check("halt_inst_valid", 64'(inst_valid), 64'(0));
         check("halt_fault_sticky", 64'(fetch_fault), 64'(1));
         rst_n = 1'b0;
         #1;
         check("halt_reset_fault", 64'(fetch_fault), 64'(0));
         tick(3);
         rst_n = 1'b1;
         tick(10);
         check("halt_reset_restart", 64'(n_acc >= 2), 64'(1));
      end
`endif

      // Asynchronous reset mid-stream clears outputs immediately
      tick(3);
      rst_n = 1'b0;
      #1;
      check("async_rst_req_valid", 64'(imem_req_valid), 64'(0));
      check("async_rst_inst_valid", 64'(inst_valid), 64'(0));
      check("async_rst_inst_pc", 64'(inst_pc), 64'(0));
      tick(2);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
